// File: rtl/ekf_step_sequencer_if.sv
// Bundle of every signal that crosses the sequencer boundary: the command
// port from the SPI decoder, the job port to the matrix engine and the
// status outputs read by the status register. The master modport is the
// sequencer's view and the slave modport is the view of its surroundings
// (command source, engine and status register together).
interface ekf_step_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
);

  // Command side
  logic              cmd_valid;
  logic [7:0]        cmd_code;
  logic              cmd_ready;
  logic              cmd_reject;

  // Matrix engine job side
  logic              eng_start;
  logic [2:0]        eng_op;
  logic [ADDR_W-1:0] eng_addr_a;
  logic [ADDR_W-1:0] eng_addr_b;
  logic [ADDR_W-1:0] eng_addr_d;
  logic              eng_abort;
  logic              eng_done;
  logic              eng_error;

  // Status side
  logic              busy;
  logic              predict_done;
  logic              update_done;
  logic              fault;
  logic [1:0]        fault_code;
  logic [CNT_W-1:0]  step_count;
  logic [3:0]        job_idx;

  modport master (
    input  cmd_valid, cmd_code, eng_done, eng_error,
    output cmd_ready, cmd_reject,
    output eng_start, eng_op, eng_addr_a, eng_addr_b, eng_addr_d, eng_abort,
    output busy, predict_done, update_done, fault, fault_code, step_count, job_idx
  );

  modport slave (
    output cmd_valid, cmd_code, eng_done, eng_error,
    input  cmd_ready, cmd_reject,
    input  eng_start, eng_op, eng_addr_a, eng_addr_b, eng_addr_d, eng_abort,
    input  busy, predict_done, update_done, fault, fault_code, step_count, job_idx
  );

endinterface

// File: rtl/ekf_step_sequencer.sv
// EKF step sequencer: walks a fixed list of matrix-engine jobs for an EKF
// predict (jobs 0-3), update (jobs 4-10) or full step (jobs 0-10), one job at
// a time over a start/done handshake, with a per-job watchdog, a sticky
// fault record and a wrapping count of completed updates.
module ekf_step_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int JOB_TIMEOUT = 800,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  ekf_step_sequencer_if.master bus
);

  localparam int DESC_W  = 3 + 3 * ADDR_W;
  localparam int TIMER_W = $clog2(JOB_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(JOB_TIMEOUT - 1);

  // EKF memory map base addresses
  localparam int ADDR_X   = 0;
  localparam int ADDR_P   = 4;
  localparam int ADDR_Q   = 20;
  localparam int ADDR_R   = 36;
  localparam int ADDR_Z   = 40;
  localparam int ADDR_F   = 42;
  localparam int ADDR_H   = 58;
  localparam int ADDR_K   = 66;
  localparam int ADDR_SCR = 82;

  // Engine opcodes
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MUL_BT = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_INV2   = 3'd4;
  localparam logic [2:0] OP_MULV   = 3'd5;
  localparam logic [2:0] OP_XCORR  = 3'd6;
  localparam logic [2:0] OP_PCORR  = 3'd7;

  // Job indices that close the predict and update halves
  localparam logic [3:0] JOB_P0 = 4'd0;
  localparam logic [3:0] JOB_P3 = 4'd3;
  localparam logic [3:0] JOB_U0 = 4'd4;
  localparam logic [3:0] JOB_U6 = 4'd10;

  localparam logic [7:0] CMD_PREDICT = 8'h10;
  localparam logic [7:0] CMD_UPDATE  = 8'h11;
  localparam logic [7:0] CMD_FULL    = 8'h12;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ENGINE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } seqState_t;

  // Packs one job descriptor as {op, a, b, d}
  function automatic logic [DESC_W-1:0] mkDesc(input logic [2:0] op, input int a,
                                               input int b, input int d);
    return {op, ADDR_W'(a), ADDR_W'(b), ADDR_W'(d)};
  endfunction

  // Fixed job table; the scratch area holds F*P, F*P*F^T, P*H^T, S and S^-1
  function automatic logic [DESC_W-1:0] jobDesc(input logic [3:0] idx);
    case (idx)
      4'd0:    return mkDesc(OP_MULV,   ADDR_F,        ADDR_X,        ADDR_X);
      4'd1:    return mkDesc(OP_MUL,    ADDR_F,        ADDR_P,        ADDR_SCR + 4);
      4'd2:    return mkDesc(OP_MUL_BT, ADDR_SCR + 4,  ADDR_F,        ADDR_SCR + 20);
      4'd3:    return mkDesc(OP_ADD,    ADDR_SCR + 20, ADDR_Q,        ADDR_P);
      4'd4:    return mkDesc(OP_MUL_BT, ADDR_P,        ADDR_H,        ADDR_SCR);
      4'd5:    return mkDesc(OP_MUL,    ADDR_H,        ADDR_SCR,      ADDR_SCR + 8);
      4'd6:    return mkDesc(OP_ADD,    ADDR_SCR + 8,  ADDR_R,        ADDR_SCR + 8);
      4'd7:    return mkDesc(OP_INV2,   ADDR_SCR + 8,  ADDR_X,        ADDR_SCR + 12);
      4'd8:    return mkDesc(OP_MUL,    ADDR_SCR,      ADDR_SCR + 12, ADDR_K);
      4'd9:    return mkDesc(OP_XCORR,  ADDR_K,        ADDR_Z,        ADDR_X);
      4'd10:   return mkDesc(OP_PCORR,  ADDR_K,        ADDR_H,        ADDR_P);
      default: return '0;
    endcase
  endfunction

  seqState_t         r_state;
  logic [DESC_W-1:0] r_desc;
  logic [3:0]        r_jobIdx;
  logic [3:0]        r_lastIdx;
  logic [TIMER_W-1:0] r_timer;
  logic              r_start;
  logic              r_abort;
  logic              r_reject;
  logic              r_busy;
  logic              r_predictDone;
  logic              r_updateDone;
  logic              r_fault;
  logic [1:0]        r_faultCode;
  logic [CNT_W-1:0]  r_stepCount;

  logic       w_runCmd;
  logic       w_resetCmd;
  logic [3:0] w_firstIdx;
  logic [3:0] w_nextIdx;

  assign w_runCmd   = bus.cmd_valid && (bus.cmd_code == CMD_PREDICT ||
                                        bus.cmd_code == CMD_UPDATE  ||
                                        bus.cmd_code == CMD_FULL);
  assign w_resetCmd = bus.cmd_valid && (bus.cmd_code == CMD_RESET);
  assign w_firstIdx = (bus.cmd_code == CMD_UPDATE) ? JOB_U0 : JOB_P0;
  assign w_nextIdx  = r_jobIdx + 4'd1;

  // Sequencer FSM: launches jobs, watches done/error/timeout and owns every status output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_desc        <= '0;
      r_jobIdx      <= '0;
      r_lastIdx     <= '0;
      r_timer       <= '0;
      r_start       <= 1'b0;
      r_abort       <= 1'b0;
      r_reject      <= 1'b0;
      r_busy        <= 1'b0;
      r_predictDone <= 1'b0;
      r_updateDone  <= 1'b0;
      r_fault       <= 1'b0;
      r_faultCode   <= 2'b00;
      r_stepCount   <= '0;
    end else begin
      r_start       <= 1'b0;
      r_abort       <= 1'b0;
      r_reject      <= 1'b0;
      r_predictDone <= 1'b0;
      r_updateDone  <= 1'b0;
      if (w_resetCmd) begin
        r_abort     <= r_busy;
        r_fault     <= 1'b0;
        r_faultCode <= 2'b00;
        r_busy      <= 1'b0;
        r_state     <= IDLE;
      end else begin
        unique case (r_state)
          IDLE, FINISH: begin
            r_state <= IDLE;
            if (w_runCmd) begin
              if (r_fault) begin
                r_reject <= 1'b1;
              end else begin
                r_jobIdx  <= w_firstIdx;
                r_desc    <= jobDesc(w_firstIdx);
                r_lastIdx <= (bus.cmd_code == CMD_PREDICT) ? JOB_P3 : JOB_U6;
                r_start   <= 1'b1;
                r_busy    <= 1'b1;
                r_state   <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (w_runCmd) r_reject <= 1'b1;
            r_timer <= '0;
            r_state <= WAIT;
          end
          WAIT: begin
            if (w_runCmd) r_reject <= 1'b1;
            if (bus.eng_done) begin
              if (r_jobIdx == JOB_P3) r_predictDone <= 1'b1;
              if (r_jobIdx == JOB_U6) begin
                r_updateDone <= 1'b1;
                r_stepCount  <= r_stepCount + CNT_W'(1);
              end
              if (r_jobIdx == r_lastIdx) begin
                r_busy  <= 1'b0;
                r_state <= FINISH;
              end else begin
                r_jobIdx <= w_nextIdx;
                r_desc   <= jobDesc(w_nextIdx);
                r_start  <= 1'b1;
                r_state  <= ISSUE;
              end
            end else if (bus.eng_error || r_timer == TIMER_LAST) begin
              r_abort <= 1'b1;
              r_fault <= 1'b1;
              if (r_faultCode == 2'b00) r_faultCode <= bus.eng_error ? FC_ENGINE : FC_TIMEOUT;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready    = 1'b1;
  assign bus.cmd_reject   = r_reject;
  assign bus.eng_start    = r_start;
  assign bus.eng_op       = r_desc[DESC_W-1 -: 3];
  assign bus.eng_addr_a   = r_desc[3*ADDR_W-1 -: ADDR_W];
  assign bus.eng_addr_b   = r_desc[2*ADDR_W-1 -: ADDR_W];
  assign bus.eng_addr_d   = r_desc[ADDR_W-1:0];
  assign bus.eng_abort    = r_abort;
  assign bus.busy         = r_busy;
  assign bus.predict_done = r_predictDone;
  assign bus.update_done  = r_updateDone;
  assign bus.fault        = r_fault;
  assign bus.fault_code   = r_faultCode;
  assign bus.step_count   = r_stepCount;
  assign bus.job_idx      = r_jobIdx;

endmodule

// File: tb/tb_ekf_step_sequencer.sv
// Bench for ekf_step_sequencer: a job-queue model of the sequence rules is
// compared against the DUT every cycle, and directed scenarios pin the model
// with hand-computed counts, latencies and descriptors. The step counter is
// built 4 bits wide so that its wrap is reachable in a short run.
module tb_ekf_step_sequencer;

  localparam int ADDR_W      = 7;
  localparam int JOB_TIMEOUT = 800;
  localparam int CNT_W       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ekf_step_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) ifc ();

  ekf_step_sequencer #(
    .ADDR_W(ADDR_W),
    .JOB_TIMEOUT(JOB_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  // Job table {op, a, b, d}, in job_idx order P0-P3, U0-U6
  logic [23:0] jobTab [0:10] = '{
    {3'd5, 7'd42,  7'd0,  7'd0},
    {3'd0, 7'd42,  7'd4,  7'd86},
    {3'd1, 7'd86,  7'd42, 7'd102},
    {3'd2, 7'd102, 7'd20, 7'd4},
    {3'd1, 7'd4,   7'd58, 7'd82},
    {3'd0, 7'd58,  7'd82, 7'd90},
    {3'd2, 7'd90,  7'd36, 7'd90},
    {3'd4, 7'd90,  7'd0,  7'd94},
    {3'd0, 7'd82,  7'd94, 7'd66},
    {3'd6, 7'd66,  7'd40, 7'd0},
    {3'd7, 7'd66,  7'd58, 7'd4}
  };

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          curJob = -1;
  int          pendQ[$];
  bit          issuing;
  int          waitCnt;
  bit          checkEn = 1'b0;
  bit          mStart, mAbort, mRej, mPd, mUd, mBusy, mFault;
  logic [1:0]  mCode;
  int          mCount;
  int          mJobIdx;
  logic [23:0] mDesc;

  task automatic startJob(input int j);
    curJob  = j;
    issuing = 1'b1;
    mStart  = 1'b1;
    mBusy   = 1'b1;
    mJobIdx = j;
    mDesc   = jobTab[j];
  endtask

  // Model advances on each rising edge from the inputs the bench is driving
  always @(posedge clk) begin
    bit runCmd;
    mStart = 1'b0; mAbort = 1'b0; mRej = 1'b0; mPd = 1'b0; mUd = 1'b0;
    runCmd = ifc.cmd_valid && (ifc.cmd_code == 8'h10 || ifc.cmd_code == 8'h11 ||
                               ifc.cmd_code == 8'h12);
    if (rst) begin
      curJob = -1; pendQ.delete(); issuing = 1'b0; waitCnt = 0;
      mBusy = 1'b0; mFault = 1'b0; mCode = 2'b00; mCount = 0; mJobIdx = 0; mDesc = '0;
      checkEn = 1'b1;
    end else if (ifc.cmd_valid && ifc.cmd_code == 8'hFF) begin
      mAbort = mBusy; mFault = 1'b0; mCode = 2'b00; mBusy = 1'b0;
      curJob = -1; pendQ.delete();
    end else if (curJob < 0) begin
      if (runCmd) begin
        if (mFault) mRej = 1'b1;
        else begin
          pendQ.delete();
          if (ifc.cmd_code != 8'h11) for (int j = 0; j < 4; j++) pendQ.push_back(j);
          if (ifc.cmd_code != 8'h10) for (int j = 4; j < 11; j++) pendQ.push_back(j);
          startJob(pendQ.pop_front());
        end
      end
    end else begin
      if (runCmd) mRej = 1'b1;
      if (issuing) begin
        issuing = 1'b0;
        waitCnt = 0;
      end else if (ifc.eng_done) begin
        if (curJob == 3) mPd = 1'b1;
        if (curJob == 10) begin
          mUd = 1'b1;
          mCount = (mCount + 1) % (1 << CNT_W);
        end
        if (pendQ.size() > 0) startJob(pendQ.pop_front());
        else begin
          curJob = -1;
          mBusy  = 1'b0;
        end
      end else begin
        waitCnt++;
        if (ifc.eng_error || waitCnt == JOB_TIMEOUT) begin
          mAbort = 1'b1;
          if (!mFault) mCode = ifc.eng_error ? 2'b10 : 2'b01;
          mFault = 1'b1;
          mBusy  = 1'b0;
          curJob = -1;
          pendQ.delete();
        end
      end
    end
  end

  // Compare DUT outputs against the model in the middle of every cycle
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("eng_start",    ifc.eng_start,    mStart);
      checkOutput("eng_abort",    ifc.eng_abort,    mAbort);
      checkOutput("cmd_reject",   ifc.cmd_reject,   mRej);
      checkOutput("cmd_ready",    ifc.cmd_ready,    1);
      checkOutput("busy",         ifc.busy,         mBusy);
      checkOutput("predict_done", ifc.predict_done, mPd);
      checkOutput("update_done",  ifc.update_done,  mUd);
      checkOutput("fault",        ifc.fault,        mFault);
      checkOutput("fault_code",   ifc.fault_code,   mCode);
      checkOutput("step_count",   ifc.step_count,   mCount);
      if (mBusy) begin
        checkOutput("descriptor", {ifc.eng_op, ifc.eng_addr_a, ifc.eng_addr_b, ifc.eng_addr_d},
                    mDesc);
        checkOutput("job_idx", ifc.job_idx, mJobIdx);
      end
    end
  end

  // ---------------- event counters for literal checks ----------------
  int          cycle = 0;
  int          startCnt = 0, pdCnt = 0, udCnt = 0, abortCnt = 0, rejCnt = 0, busyCyc = 0;
  int          pdCycle = 0, abortCycle = 0;
  int          startCycle [0:10];
  logic [23:0] startLog [0:10];

  // Tally output events so scenarios can compare against hand-computed numbers
  always @(negedge clk) begin
    cycle++;
    if (checkEn) begin
      if (ifc.eng_start) begin
        startCnt++;
        if (int'(ifc.job_idx) < 11) begin
          startCycle[ifc.job_idx] = cycle;
          startLog[ifc.job_idx]   = {ifc.eng_op, ifc.eng_addr_a, ifc.eng_addr_b, ifc.eng_addr_d};
        end
      end
      if (ifc.predict_done) begin pdCnt++; pdCycle = cycle; end
      if (ifc.update_done) udCnt++;
      if (ifc.eng_abort) begin abortCnt++; abortCycle = cycle; end
      if (ifc.cmd_reject) rejCnt++;
      if (ifc.busy) busyCyc++;
    end
  end

  // ---------------- engine responder ----------------
  // kind: 0 done, 1 done+error together, 2 error only, 3 never answers
  int respDelay [0:10];
  int respKind  [0:10];
  bit armed = 1'b0;
  int armCnt, armJob;

  // Answers each job respDelay cycles after its start pulse
  always @(negedge clk) begin
    ifc.eng_done  = 1'b0;
    ifc.eng_error = 1'b0;
    if (rst || ifc.eng_abort) armed = 1'b0;
    else if (armed) begin
      armCnt--;
      if (armCnt == 0) begin
        armed = 1'b0;
        case (respKind[armJob])
          0: ifc.eng_done = 1'b1;
          1: begin ifc.eng_done = 1'b1; ifc.eng_error = 1'b1; end
          2: ifc.eng_error = 1'b1;
          default: ;
        endcase
      end
    end
    if (ifc.eng_start && !rst && int'(ifc.job_idx) < 11) begin
      armJob = int'(ifc.job_idx);
      armCnt = respDelay[armJob];
      armed  = (respKind[armJob] != 3);
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [7:0] code);
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_code  = code;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    ifc.cmd_code  = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (ifc.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, ifc.busy, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"},       ifc.busy,         0);
    checkOutput({tag, " eng_start"},  ifc.eng_start,    0);
    checkOutput({tag, " eng_abort"},  ifc.eng_abort,    0);
    checkOutput({tag, " fault"},      ifc.fault,        0);
    checkOutput({tag, " fault_code"}, ifc.fault_code,   0);
    checkOutput({tag, " step_count"}, ifc.step_count,   0);
    checkOutput({tag, " job_idx"},    ifc.job_idx,      0);
    checkOutput({tag, " descriptor"}, {ifc.eng_op, ifc.eng_addr_a, ifc.eng_addr_b, ifc.eng_addr_d}, 0);
    checkOutput({tag, " update_done"}, ifc.update_done, 0);
    checkOutput({tag, " cmd_ready"},  ifc.cmd_ready,    1);
  endtask

  initial begin
    int s0, p0, u0, a0, r0, b0, n;
    bit found;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_code  = 8'h00;
    for (int i = 0; i < 11; i++) begin
      respDelay[i] = 3;
      respKind[i]  = 0;
    end

    // Power-on reset
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;

    // Predict: four jobs of ISSUE + 3 WAIT cycles each
    s0 = startCnt; p0 = pdCnt; u0 = udCnt; b0 = busyCyc;
    applyStimulus(8'h10);
    waitIdle(200, "predict completes");
    tick(2);
    checkOutput("predict starts",      startCnt - s0, 4);
    checkOutput("predict_done pulses", pdCnt - p0,    1);
    checkOutput("predict update_done", udCnt - u0,    0);
    checkOutput("predict busy cycles", busyCyc - b0,  16);
    checkOutput("predict step_count",  ifc.step_count, 0);
    checkOutput("P0 descriptor",       startLog[0], {3'd5, 7'd42, 7'd0, 7'd0});
    checkOutput("P3 descriptor",       startLog[3], {3'd2, 7'd102, 7'd20, 7'd4});

    // Full step: eleven jobs, predict_done lands on the U0 launch cycle
    s0 = startCnt; p0 = pdCnt; u0 = udCnt; b0 = busyCyc;
    applyStimulus(8'h12);
    waitIdle(300, "full step completes");
    tick(2);
    checkOutput("full starts",          startCnt - s0, 11);
    checkOutput("full predict_done",    pdCnt - p0,    1);
    checkOutput("full update_done",     udCnt - u0,    1);
    checkOutput("full busy cycles",     busyCyc - b0,  44);
    checkOutput("full step_count",      ifc.step_count, 1);
    checkOutput("P3 to U0 spacing",     startCycle[4] - startCycle[3], 4);
    checkOutput("predict_done at U0",   pdCycle, startCycle[4]);
    checkOutput("U6 descriptor",        startLog[10], {3'd7, 7'd66, 7'd58, 7'd4});

    // Timeout on U2, then reject while faulted, then clear with 0xFF
    respKind[6] = 3;
    s0 = startCnt; u0 = udCnt; a0 = abortCnt; r0 = rejCnt;
    applyStimulus(8'h11);
    n = 0;
    while (abortCnt == a0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout abort seen",    abortCnt - a0, 1);
    checkOutput("timeout abort latency", abortCycle - startCycle[6], 801);
    tick(1);
    checkOutput("timeout fault",      ifc.fault,      1);
    checkOutput("timeout fault_code", ifc.fault_code, 2'b01);
    checkOutput("timeout busy",       ifc.busy,       0);
    checkOutput("timeout no update",  udCnt - u0,     0);
    s0 = startCnt;
    applyStimulus(8'h10);
    tick(1);
    checkOutput("faulted run rejected", rejCnt - r0,   1);
    checkOutput("faulted run no start", startCnt - s0, 0);
    applyStimulus(8'hFF);
    tick(1);
    checkOutput("0xFF clears fault",      ifc.fault,      0);
    checkOutput("0xFF clears fault_code", ifc.fault_code, 0);
    checkOutput("idle 0xFF no abort",     abortCnt - a0,  1);
    checkOutput("step_count kept",        ifc.step_count, 1);
    respKind[6] = 0;

    // Done+error on P1 counts as done; error alone on P2 faults
    respKind[1] = 1;
    respKind[2] = 2;
    s0 = startCnt; p0 = pdCnt;
    applyStimulus(8'h10);
    waitIdle(200, "error run stops");
    tick(1);
    checkOutput("error run starts",  startCnt - s0,  3);
    checkOutput("error fault",       ifc.fault,      1);
    checkOutput("error fault_code",  ifc.fault_code, 2'b10);
    checkOutput("error no predict",  pdCnt - p0,     0);
    applyStimulus(8'hFF);
    tick(1);
    respKind[1] = 0;
    respKind[2] = 0;

    // Reject while busy, ignored code, then 0xFF during U4 WAIT
    respDelay[8] = 20;
    s0 = startCnt; u0 = udCnt; a0 = abortCnt; r0 = rejCnt;
    applyStimulus(8'h11);
    tick(1);
    applyStimulus(8'h11);
    applyStimulus(8'h33);
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      found = ifc.eng_start && ifc.job_idx == 4'd8;
      n++;
    end
    checkOutput("U4 launched", found, 1);
    tick(3);
    applyStimulus(8'hFF);
    tick(1);
    checkOutput("busy run rejected",   rejCnt - r0,    1);
    checkOutput("abort run starts",    startCnt - s0,  5);
    checkOutput("abort run no update", udCnt - u0,     0);
    checkOutput("0xFF abort pulse",    abortCnt - a0,  1);
    checkOutput("0xFF returns idle",   ifc.busy,       0);
    checkOutput("0xFF no fault",       ifc.fault,      0);
    checkOutput("abort step_count",    ifc.step_count, 1);
    respDelay[8] = 3;

    // Drive step_count to its top value, then wrap it
    for (int k = 0; k < 14; k++) begin
      applyStimulus(8'h11);
      waitIdle(200, "update run completes");
    end
    tick(1);
    checkOutput("step_count at top", ifc.step_count, 4'hF);
    u0 = udCnt;
    applyStimulus(8'h11);
    waitIdle(200, "wrap update completes");
    tick(1);
    checkOutput("step_count wraps",  ifc.step_count, 0);
    checkOutput("wrap update_done",  udCnt - u0,     1);

    // Reset in the middle of a full step
    applyStimulus(8'h12);
    tick(10);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("mid-run reset");
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
